rv_ifu: RTL and testbench
=========================

# rv_ifu

Instruction fetch unit, the stage directly upstream of the instruction TCM. It owns the fetch PC, drives the TCM read address, and pairs each 1-cycle-latency TCM read word with its PC. Results pass through a 2-entry skid FIFO to decode under a valid/ready handshake. It also handles redirects from execute by flushing everything in flight.

## Interface
- `RESET_PC`, default `` `MXLEN'h0000_0000 ``: fetch address after reset.
- `clk` in 1: core clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `redirect_i` in 1: flush and restart fetch at `redirect_pc_i`.
- `redirect_pc_i` in `` `MXLEN ``: redirect target. Bits [1:0] are ignored and treated as 0.
- `itcm_pc_o` out `` `MXLEN ``: read address to the instruction TCM. The TCM samples it every cycle.
- `itcm_instr_i` in 32: TCM read data for the address presented one cycle earlier.
- `if_valid_o` out 1: a fetched instruction is available.
- `if_ready_i` in 1: decode accepts the instruction.
- `if_pc_o` out `` `MXLEN ``: PC of the presented instruction.
- `if_instr_o` out 32: presented instruction word.

## Operation
- **State:**
  - `pc_q`: next fetch address.
  - `infl`: 1-bit in-flight flag, with `infl_pc`.
  - 2-entry FIFO of {pc, instr}, with `count` in the range 0..2.
- **Reset values:**
  - `pc_q`=RESET_PC, `infl`=0, `count`=0.
  - FIFO storage = 0.
  - `if_valid_o`=0, `if_pc_o`=0, `if_instr_o`=0, `itcm_pc_o`=RESET_PC.
- **Address path:** `itcm_pc_o` = `pc_q` at all times.
- **Pop:** `pop` = `if_valid_o && if_ready_i`. The head advances on pop.
- **Issue:** `issue` = `!redirect_i && (count + infl - pop) < 2`. On issue:
  - `infl` <= 1, `infl_pc` <= `pc_q`.
  - `pc_q` <= `pc_q + 4`, wrapping modulo 2^MXLEN.
  - Otherwise `infl` <= 0 and `pc_q` holds.
- **Capture:** when `infl`=1 and there is no redirect, push {`infl_pc`, `itcm_instr_i`}. Space is guaranteed by the issue rule.
- **Simultaneous push and pop:** `count` is unchanged and ordering is preserved.
- **Redirect (highest priority):**
  - `count` <= 0 and `infl` <= 0; in-flight data is discarded.
  - `pc_q` <= {`redirect_pc_i`[MXLEN-1:2], 2'b00}.
  - No issue that cycle.
  - A pop coincident with a redirect still completes the handshake, but the entry is considered squashed by decode.
- **Outputs:** `if_valid_o` = (`count` != 0). `if_pc_o`/`if_instr_o` show the FIFO head.
- **Asynchronous reset mid-operation:** all state returns to its reset values immediately, and fetch restarts at RESET_PC.

## Timing
- **Read latency:** the address issued in cycle N has its data on `itcm_instr_i` in N+1, is pushed at the end of N+1, and is visible on `if_valid_o` in N+2.
- **After reset release:** the first edge issues RESET_PC, and `if_valid_o` rises after the 2nd edge.
- **Redirect in cycle R:** `itcm_pc_o` = target in R+1, and `if_valid_o`=1 with `if_pc_o`=target in R+3. `if_valid_o`=0 in R+1 and R+2.
- **Throughput:** 1 instruction/cycle with `if_ready_i` held high. Steady state is `count`=1, `infl`=1.
- **Backpressure:**
  - With `if_ready_i` low, at most 2 entries are buffered and issue stops (`count`+`infl` ≤ 2).
  - No word is lost or duplicated.
  - `if_pc_o`/`if_instr_o` stay stable while valid and not ready.

## Configuration
- **`RV_IFU_BYPASS_EN` defined:** when `count`=0 and `infl`=1 (no redirect), the block presents `infl_pc`/`itcm_instr_i` combinationally.
  - `if_valid_o` = (`count`!=0) || (`infl` && !`redirect_i`).
  - If that word is popped in the same cycle, it is not pushed.
  - Latency shortens by one cycle: valid after reset at the 1st-edge+1 cycle, and a redirect yields valid in R+2.
  - The issue rule is unchanged.
- **Not defined:** outputs come only from FIFO registers, with the latencies given in Timing.

## Test plan
- **Reset:** RESET_PC=0x100, ready=1, TCM model returns word = address. Required: valid from cycle 2, PCs 0x100, 0x104, 0x108… every cycle, and instr==pc.
- **Backpressure:** drop ready for 5 cycles after PC 0x108 is presented. Required: 0x108 is held stable, `itcm_pc_o` stops advancing, and on ready the block resumes 0x10C, 0x110 with no gap or duplicate.
- **Redirect:** pulse redirect to 0x2003 while 2 entries are buffered. Required: FIFO is empty next cycle, valid is low for 2 cycles, then PC 0x2000.
- **Redirect colliding with a pop and an in-flight word:** the in-flight word must never appear on the outputs.
- **Wrap-around:** redirect to 0xFFFF_FFFC. Required: PCs 0xFFFF_FFFC then 0x0000_0000.
- **Asynchronous reset mid-stream:** assert `rst_n` low between edges with `count`=2. Required: valid=0 immediately and fetch restarts at RESET_PC. Repeat the reset, redirect and backpressure scenarios with `RV_IFU_BYPASS_EN` defined and check the one-cycle-shorter latencies.

Source files
------------

// File: rtl/rv_ifu.sv
// Instruction fetch unit: owns the fetch PC, pairs 1-cycle TCM read data with its PC, 2-entry skid FIFO to decode.
// Optional feature macro: RV_IFU_BYPASS_EN (present the in-flight word combinationally when the FIFO is empty).
`ifndef MXLEN
`define MXLEN 32
`endif

module rv_ifu #(
  parameter logic [`MXLEN-1:0] RESET_PC = {`MXLEN{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_i,
  input  logic [`MXLEN-1:0] redirect_pc_i,
  output logic [`MXLEN-1:0] itcm_pc_o,
  input  logic [31:0]       itcm_instr_i,
  output logic              if_valid_o,
  input  logic              if_ready_i,
  output logic [`MXLEN-1:0] if_pc_o,
  output logic [31:0]       if_instr_o
);
  localparam int XL = `MXLEN;

  logic [XL-1:0] r_pc;
  logic [XL-1:0] r_infl_pc;
  logic          r_infl;
  logic [1:0]    r_count;
  logic          r_head;
  logic [XL-1:0] r_fifo_pc    [2];
  logic [31:0]   r_fifo_instr [2];

  logic          w_bypass;
  logic          w_pop;
  logic          w_fifo_pop;
  logic          w_push;
  logic          w_issue;
  logic [2:0]    w_occ;
  logic          w_wr_idx;
  logic [XL-1:0] w_redirect_pc;

`ifdef RV_IFU_BYPASS_EN
  assign w_bypass = (r_count == 2'd0) && r_infl && !redirect_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign itcm_pc_o  = r_pc;
  assign if_valid_o = (r_count != 2'd0) || w_bypass;
  assign if_pc_o    = w_bypass ? r_infl_pc    : r_fifo_pc[r_head];
  assign if_instr_o = w_bypass ? itcm_instr_i : r_fifo_instr[r_head];

  assign w_pop      = if_valid_o && if_ready_i;
  // A bypassed word that is accepted never enters the FIFO, so only FIFO-sourced pops move the head.
  assign w_fifo_pop = w_pop && (r_count != 2'd0);
  assign w_push     = r_infl && !redirect_i && !(w_bypass && w_pop);
  assign w_occ      = {1'b0, r_count} + {2'b00, r_infl} - {2'b00, w_pop};
  assign w_issue    = !redirect_i && (w_occ < 3'd2);
  assign w_wr_idx   = r_head ^ r_count[0];
  assign w_redirect_pc = redirect_pc_i & ~{{(XL-2){1'b0}}, 2'b11};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_infl    <= 1'b0;
      r_infl_pc <= '0;
      r_count   <= 2'd0;
      r_head    <= 1'b0;
    end else if (redirect_i) begin
      r_pc    <= w_redirect_pc;
      r_infl  <= 1'b0;
      r_count <= 2'd0;
      r_head  <= 1'b0;
    end else begin
      r_infl <= w_issue;
      if (w_issue) begin
        r_infl_pc <= r_pc;
        r_pc      <= r_pc + XL'(4);
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_fifo_pop};
      if (w_fifo_pop) r_head <= ~r_head;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_fifo_pc[gi]    <= '0;
          r_fifo_instr[gi] <= '0;
        end else if (w_push && (w_wr_idx == 1'(gi))) begin
          r_fifo_pc[gi]    <= r_infl_pc;
          r_fifo_instr[gi] <= itcm_instr_i;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_rv_ifu.sv
// Directed bench for rv_ifu: TCM model returns word == address; expected PCs are hand-derived per scenario.
`ifndef MXLEN
`define MXLEN 32
`endif

module tb_rv_ifu;
`ifdef RV_IFU_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic [31:0] itcm_pc_o;
  logic [31:0] itcm_instr_i = 32'h0;
  logic        if_valid_o;
  logic        if_ready_i = 1'b0;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) itcm_instr_i <= itcm_pc_o;

  rv_ifu #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .itcm_pc_o    (itcm_pc_o),
    .itcm_instr_i (itcm_instr_i),
    .if_valid_o   (if_valid_o),
    .if_ready_i   (if_ready_i),
    .if_pc_o      (if_pc_o),
    .if_instr_o   (if_instr_o)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 (before the first post-reset edge), outputs settled.
  task automatic reset_dut();
    rst_n = 1'b0; redirect_i = 1'b0; if_ready_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_dut();
    n_total++; if (if_valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", if_valid_o); else n_pass++;
    n_total++; if (if_pc_o !== 32'h0) $display("FAIL reset_pc got=%h exp=0", if_pc_o); else n_pass++;
    n_total++; if (if_instr_o !== 32'h0) $display("FAIL reset_instr got=%h exp=0", if_instr_o); else n_pass++;
    n_total++; if (itcm_pc_o !== RST_PC) $display("FAIL reset_itcm got=%h exp=%h", itcm_pc_o, RST_PC); else n_pass++;
    $display("reset: valid=%b pc=%h itcm=%h", if_valid_o, if_pc_o, itcm_pc_o);
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      #1;
      exp_pc = RST_PC + 32'(4 * (k - LAT));
      $display("stream cyc %0d: valid=%b pc=%h instr=%h itcm=%h", k, if_valid_o, if_pc_o, if_instr_o, itcm_pc_o);
      n_total++; if (itcm_pc_o !== RST_PC + 32'(4 * k)) $display("FAIL stream_itcm cyc%0d got=%h exp=%h", k, itcm_pc_o, RST_PC + 32'(4 * k)); else n_pass++;
      n_total++; if (if_valid_o !== (k >= LAT)) $display("FAIL stream_valid cyc%0d got=%b exp=%b", k, if_valid_o, (k >= LAT)); else n_pass++;
      if (k >= LAT) begin
        n_total++; if (if_pc_o !== exp_pc) $display("FAIL stream_pc cyc%0d got=%h exp=%h", k, if_pc_o, exp_pc); else n_pass++;
        n_total++; if (if_instr_o !== exp_pc) $display("FAIL stream_instr cyc%0d got=%h exp=%h", k, if_instr_o, exp_pc); else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    bit found = 0;
    logic [31:0] exp_pc;
    reset_dut();
    for (int k = 0; k < 10 && !found; k++) begin
      cyc();
      #1;
      if (if_valid_o === 1'b1 && if_pc_o === 32'h108) found = 1;
    end
    n_total++; if (!found) $display("FAIL bp_find got=timeout exp=pc 00000108"); else n_pass++;
    if_ready_i = 1'b0;
    for (int h = 1; h <= 4; h++) begin
      cyc();
      #1;
      $display("bp hold %0d: valid=%b pc=%h itcm=%h", h, if_valid_o, if_pc_o, itcm_pc_o);
      n_total++; if (if_valid_o !== 1'b1) $display("FAIL bp_hold_valid h%0d got=%b exp=1", h, if_valid_o); else n_pass++;
      n_total++; if (if_pc_o !== 32'h108) $display("FAIL bp_hold_pc h%0d got=%h exp=00000108", h, if_pc_o); else n_pass++;
      n_total++; if (if_instr_o !== 32'h108) $display("FAIL bp_hold_instr h%0d got=%h exp=00000108", h, if_instr_o); else n_pass++;
      n_total++; if (itcm_pc_o !== 32'h110) $display("FAIL bp_hold_itcm h%0d got=%h exp=00000110", h, itcm_pc_o); else n_pass++;
    end
    cyc();
    if_ready_i = 1'b1;
    #1;
    n_total++; if (if_pc_o !== 32'h108) $display("FAIL bp_release_pc got=%h exp=00000108", if_pc_o); else n_pass++;
    for (int j = 1; j <= 4; j++) begin
      cyc();
      #1;
      exp_pc = 32'h108 + 32'(4 * j);
      $display("bp resume %0d: valid=%b pc=%h", j, if_valid_o, if_pc_o);
      n_total++; if (if_valid_o !== 1'b1) $display("FAIL bp_resume_valid j%0d got=%b exp=1", j, if_valid_o); else n_pass++;
      n_total++; if (if_pc_o !== exp_pc) $display("FAIL bp_resume_pc j%0d got=%h exp=%h", j, if_pc_o, exp_pc); else n_pass++;
      n_total++; if (if_instr_o !== exp_pc) $display("FAIL bp_resume_instr j%0d got=%h exp=%h", j, if_instr_o, exp_pc); else n_pass++;
    end
  endtask

  task automatic test_redirect();
    logic [31:0] exp_pc;
    reset_dut();
    repeat (4) cyc();
    if_ready_i = 1'b0;
    repeat (3) cyc();
    redirect_i = 1'b1; redirect_pc_i = 32'h2003;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 1) begin redirect_i = 1'b0; if_ready_i = 1'b1; end
      #1;
      exp_pc = 32'h2000 + 32'(4 * (k - LAT - 1));
      $display("redirect R+%0d: valid=%b pc=%h itcm=%h", k, if_valid_o, if_pc_o, itcm_pc_o);
      if (k == 1) begin
        n_total++; if (itcm_pc_o !== 32'h2000) $display("FAIL redir_itcm got=%h exp=00002000", itcm_pc_o); else n_pass++;
      end
      n_total++; if (if_valid_o !== (k >= LAT + 1)) $display("FAIL redir_valid R+%0d got=%b exp=%b", k, if_valid_o, (k >= LAT + 1)); else n_pass++;
      if (k >= LAT + 1) begin
        n_total++; if (if_pc_o !== exp_pc) $display("FAIL redir_pc R+%0d got=%h exp=%h", k, if_pc_o, exp_pc); else n_pass++;
        n_total++; if (if_instr_o !== exp_pc) $display("FAIL redir_instr R+%0d got=%h exp=%h", k, if_instr_o, exp_pc); else n_pass++;
      end
    end
  endtask

  task automatic test_redirect_collide();
    logic [31:0] exp_pc;
    reset_dut();
    repeat (5) cyc();
    redirect_i = 1'b1; redirect_pc_i = 32'h3000;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 1) redirect_i = 1'b0;
      #1;
      exp_pc = 32'h3000 + 32'(4 * (k - LAT - 1));
      $display("collide R+%0d: valid=%b pc=%h", k, if_valid_o, if_pc_o);
      n_total++; if (if_valid_o !== (k >= LAT + 1)) $display("FAIL coll_valid R+%0d got=%b exp=%b", k, if_valid_o, (k >= LAT + 1)); else n_pass++;
      if (k >= LAT + 1) begin
        n_total++; if (if_pc_o !== exp_pc) $display("FAIL coll_pc R+%0d got=%h exp=%h", k, if_pc_o, exp_pc); else n_pass++;
      end
    end
  endtask

  task automatic test_wrap();
    reset_dut();
    cyc();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    for (int k = 1; k <= LAT + 2; k++) begin
      cyc();
      if (k == 1) redirect_i = 1'b0;
      #1;
      $display("wrap R+%0d: valid=%b pc=%h itcm=%h", k, if_valid_o, if_pc_o, itcm_pc_o);
      if (k == 2) begin
        n_total++; if (itcm_pc_o !== 32'h0) $display("FAIL wrap_itcm got=%h exp=00000000", itcm_pc_o); else n_pass++;
      end
      if (k == LAT + 1) begin
        n_total++; if (if_valid_o !== 1'b1) $display("FAIL wrap_valid0 got=%b exp=1", if_valid_o); else n_pass++;
        n_total++; if (if_pc_o !== 32'hFFFF_FFFC) $display("FAIL wrap_pc0 got=%h exp=fffffffc", if_pc_o); else n_pass++;
      end
      if (k == LAT + 2) begin
        n_total++; if (if_pc_o !== 32'h0) $display("FAIL wrap_pc1 got=%h exp=00000000", if_pc_o); else n_pass++;
        n_total++; if (if_instr_o !== 32'h0) $display("FAIL wrap_instr1 got=%h exp=00000000", if_instr_o); else n_pass++;
      end
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    repeat (4) cyc();
    if_ready_i = 1'b0;
    repeat (3) cyc();
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: valid=%b pc=%h itcm=%h", if_valid_o, if_pc_o, itcm_pc_o);
    n_total++; if (if_valid_o !== 1'b0) $display("FAIL arst_valid got=%b exp=0", if_valid_o); else n_pass++;
    n_total++; if (if_pc_o !== 32'h0) $display("FAIL arst_pc got=%h exp=0", if_pc_o); else n_pass++;
    n_total++; if (itcm_pc_o !== RST_PC) $display("FAIL arst_itcm got=%h exp=%h", itcm_pc_o, RST_PC); else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1; if_ready_i = 1'b1;
    #1;
    for (int k = 1; k <= LAT; k++) begin
      cyc();
      #1;
      if (k == LAT) begin
        n_total++; if (if_valid_o !== 1'b1) $display("FAIL arst_restart_valid got=%b exp=1", if_valid_o); else n_pass++;
        n_total++; if (if_pc_o !== RST_PC) $display("FAIL arst_restart_pc got=%h exp=%h", if_pc_o, RST_PC); else n_pass++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_collide();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
